// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit for the EX stage.
// One product or quotient bit per cycle; holds the front of the pipe while busy.
module ex_muldiv (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [2:0]  op,
   input  logic        word,
   input  logic [63:0] rs1Data,
   input  logic [63:0] rs2Data,
   output logic        stall,
   output logic        done,
   output logic [63:0] result
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t       state_q, state_d;
   logic [6:0]   cnt_q, cnt_d;
   logic [63:0]  ma_q, ma_d, mb_q, mb_d;
   logic [127:0] acc_q, acc_d;
   logic [2:0]   op_q, op_d;
   logic         word_q, word_d, sa_q, sa_d, sb_q, sb_d;
   logic         done_q, done_d;
   logic [63:0]  result_q, result_d;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   logic               sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
   logic signed [63:0] a_ext, b_ext;
   logic [63:0]        a_min, mag_a, mag_b;

   always_comb begin
      sgn_a    = !(op[0] && (op[1] || op[2]));
      sgn_b    = sgn_a && (op != 3'b010);
      a_ext    = word ? (sgn_a ? sext32(rs1Data[31:0]) : {32'd0, rs1Data[31:0]}) : rs1Data;
      b_ext    = word ? (sgn_b ? sext32(rs2Data[31:0]) : {32'd0, rs2Data[31:0]}) : rs2Data;
      neg_a    = sgn_a && a_ext[63];
      neg_b    = sgn_b && b_ext[63];
      mag_a    = neg_a ? -a_ext : a_ext;
      mag_b    = neg_b ? -b_ext : b_ext;
      a_min    = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      div_zero = op[2] && (b_ext == 64'sd0);
      div_ovf  = op[2] && !op[0] && (a_ext == a_min) && (b_ext == -64'sd1);
   end

   // Iteration step (CALC) and sign/selection (FIX) datapath
   logic [64:0]         mul_sum, rem_sh;
   logic [63:0]         rem_sub, quo_s, rem_s, fix_res;
   logic                rem_ge;
   logic [127:0]        prod;
   logic signed [127:0] prod_s;

   always_comb begin
      mul_sum = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, ma_q} : 65'd0);
      rem_sh  = {acc_q[127:64], acc_q[63]};
      rem_ge  = rem_sh >= {1'b0, mb_q};
      rem_sub = rem_sh[63:0] - mb_q;
      prod    = word_q ? {32'd0, acc_q[127:32]} : acc_q;
      prod_s  = (sa_q ^ sb_q) ? -$signed(prod) : $signed(prod);
      quo_s   = (sa_q ^ sb_q) ? -acc_q[63:0] : acc_q[63:0];
      rem_s   = sa_q ? -acc_q[127:64] : acc_q[127:64];
      case (op_q)
         3'b000:                 fix_res = prod_s[63:0];
         3'b001, 3'b010, 3'b011: fix_res = word_q ? 64'd0 : prod_s[127:64];
         3'b100, 3'b101:         fix_res = quo_s;
         default:                fix_res = rem_s;
      endcase
      if (word_q) fix_res = sext32(fix_res[31:0]);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      acc_d    = acc_q;
      op_d     = op_q;
      word_d   = word_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      done_d   = 1'b0;
      result_d = result_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               ma_d   = mag_a;
               mb_d   = mag_b;
               op_d   = op;
               word_d = word;
               sa_d   = neg_a;
               sb_d   = neg_b;
               cnt_d  = word ? 7'd32 : 7'd64;
               // Divide left-aligns the dividend so its MSB is shifted out first
               acc_d  = op[2] ? {64'd0, (word ? {mag_a[31:0], 32'd0} : mag_a)}
                             : {64'd0, mag_b};
               if (div_zero || div_ovf) begin
                  state_d  = DONE;
                  done_d   = 1'b1;
                  result_d = div_zero ? (op[1] ? a_ext : 64'hFFFF_FFFF_FFFF_FFFF)
                                      : (op[1] ? 64'd0 : a_ext);
                  if (word) result_d = sext32(result_d[31:0]);
               end else begin
                  state_d = CALC;
               end
            end
            CALC: begin
               cnt_d = cnt_q - 7'd1;
               acc_d = op_q[2] ? {(rem_ge ? rem_sub : rem_sh[63:0]), acc_q[62:0], rem_ge}
                               : {mul_sum, acc_q[63:1]};
               if (cnt_q == 7'd1) state_d = FIX;
            end
            FIX: begin
               state_d  = DONE;
               done_d   = 1'b1;
               result_d = fix_res;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 7'd0;
         ma_q     <= 64'd0;
         mb_q     <= 64'd0;
         acc_q    <= 128'd0;
         op_q     <= 3'd0;
         word_q   <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 64'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         word_q   <= word_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign stall  = ((state_q == IDLE) && start) || (state_q == CALC) || (state_q == FIX);
   assign done   = done_q;
   assign result = result_q;
endmodule
